// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I front end: fetch state encoding,
// PC increment and the default reset/timeout settings.
package rv32i_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam int unsigned DEF_TIMEOUT   = 255;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response channel between the fetch
// controller (master) and the instruction memory (slave).
interface fetch_ctrl_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_ctrl_redirect_mux.sv
// Selects the redirect target (trap over branch), word-aligns it and
// flags targets whose low address bits were non-zero.
module redirect_mux
  import rv32i_pkg::*;
(
  input  logic        trap,
  input  logic [31:0] trap_addr,
  input  logic        branch,
  input  logic [31:0] branch_addr,
  output logic        redir,
  output logic [31:0] redir_tgt,
  output logic        redir_misalign
);

  logic [31:0] raw_tgt;

  always_comb begin
    raw_tgt        = trap ? trap_addr : branch_addr;
    redir          = trap | branch;
    redir_tgt      = align_word(raw_tgt);
    redir_misalign = redir & (raw_tgt[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one word request at a time, presents
// fetched words to decode, and handles stalls, redirects and fetch timeouts.
module fetch_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch,
  input  logic [31:0]         branch_addr,
  input  logic                trap,
  input  logic [31:0]         trap_addr,
  input  logic                stall,
  fetch_ctrl_if.master        imem,
  output logic                inst_valid,
  output logic [31:0]         inst,
  output logic [31:0]         inst_pc,
  output logic                misalign,
  output logic                fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         kill_q, kill_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         misalign_q, misalign_d;
  logic         fetch_err_q, fetch_err_d;

  logic         req;
  logic         hold;
  logic         redir;
  logic [31:0]  redir_tgt;
  logic         redir_mis;

  redirect_mux u_redirect_mux (
    .trap           (trap),
    .trap_addr      (trap_addr),
    .branch         (branch),
    .branch_addr    (branch_addr),
    .redir          (redir),
    .redir_tgt      (redir_tgt),
    .redir_misalign (redir_mis)
  );

  // A presented word that decode refuses must not be overwritten, so no new request goes out.
  assign hold = inst_valid_q & stall;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    kill_d       = kill_q;
    wait_cnt_d   = wait_cnt_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    misalign_d   = 1'b0;
    fetch_err_d  = fetch_err_q;
    req          = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (hold) begin
          if (redir) begin
            pc_d       = redir_tgt;
            misalign_d = redir_mis;
          end else begin
            state_d      = ST_HOLD;
            inst_valid_d = 1'b1;
          end
        end else begin
          req = 1'b1;
          if (imem.imem_ack) begin
            wait_cnt_d = '0;
            kill_d     = 1'b0;
            if (redir) begin
              pc_d       = redir_tgt;
              misalign_d = redir_mis;
            end else if (kill_q) begin
              pc_d = pend_pc_q;
            end else begin
              inst_d       = imem.imem_rdata;
              inst_pc_d    = pc_q;
              inst_valid_d = 1'b1;
              pc_d         = pc_q + PC_INC;
            end
          end else begin
            // The request stays on the bus; the redirect is parked until its ack drains.
            wait_cnt_d = wait_cnt_q + 1'b1;
            if (redir) begin
              kill_d     = 1'b1;
              pend_pc_d  = redir_tgt;
              misalign_d = redir_mis;
            end
            if (wait_cnt_d > CNT_W'(TIMEOUT)) begin
              state_d     = ST_ERR;
              fetch_err_d = 1'b1;
            end
          end
        end
      end

      ST_HOLD: begin
        if (redir) begin
          pc_d       = redir_tgt;
          misalign_d = redir_mis;
          state_d    = ST_FETCH;
        end else if (!stall) begin
          state_d = ST_FETCH;
        end else begin
          inst_valid_d = 1'b1;
        end
      end

      ST_ERR: begin
        fetch_err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VEC;
      pend_pc_q    <= ZERO_WORD;
      kill_q       <= 1'b0;
      wait_cnt_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= ZERO_WORD;
      inst_pc_q    <= ZERO_WORD;
      misalign_q   <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      kill_q       <= kill_d;
      wait_cnt_q   <= wait_cnt_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      misalign_q   <= misalign_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign misalign       = misalign_q;
  assign fetch_err      = fetch_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a memory model answers requests, a monitor
// compares accepted requests and decoded instructions against queued expectations.
module tb_fetch_ctrl;

  localparam logic [31:0] MASK = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch, trap, stall;
  logic [31:0] branch_addr, trap_addr;
  logic        inst_valid, misalign, fetch_err;
  logic [31:0] inst, inst_pc;

  fetch_ctrl_if imem();

  logic        mem_ack, ovr_ack;
  logic [31:0] mem_rdata, ovr_rdata;
  int          mem_lat = 1;
  int          ack_limit = 0;
  int          acks_given;
  int          mcnt;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] mon_val;
  int          mis_cnt;

  assign imem.imem_ack   = mem_ack | ovr_ack;
  assign imem.imem_rdata = ovr_ack ? ovr_rdata : mem_rdata;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .branch      (branch),
    .branch_addr (branch_addr),
    .trap        (trap),
    .trap_addr   (trap_addr),
    .stall       (stall),
    .imem        (imem),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .misalign    (misalign),
    .fetch_err   (fetch_err)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int lat, input int budget);
    @(negedge clk);
    rst = 1'b0; branch = 1'b0; trap = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clk);
    mem_lat   = lat;
    ack_limit = acks_given + budget;
    rst       = 1'b1;
  endtask

  task automatic wait_addr(input string name, input logic [31:0] a);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk); #3;
      if (imem.imem_req && imem.imem_addr == a) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s: request for %h not seen within 40 cycles", name, a);
    end
  endtask

  task automatic check_drained(input string name);
    check32({name, "_addr_left"}, exp_addr_q.size(), 32'd0);
    check32({name, "_inst_left"}, exp_pc_q.size(), 32'd0);
    exp_addr_q.delete();
    exp_pc_q.delete();
  endtask

  // Instruction memory: answers after mem_lat request cycles while budget remains.
  initial begin
    mem_ack = 1'b0; mem_rdata = '0; mcnt = 0; acks_given = 0;
    forever begin
      @(negedge clk); #1;
      mem_ack = 1'b0;
      if (rst !== 1'b1) begin
        mcnt = 0;
      end else if (imem.imem_req && acks_given < ack_limit) begin
        mcnt++;
        if (mcnt >= mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = imem.imem_addr ^ MASK;
          mcnt      = 0;
          acks_given++;
        end
      end
    end
  end

  // Monitor: every accepted request and every consumed instruction pops one expectation.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rst === 1'b1) begin
        if (imem.imem_req && imem.imem_ack) begin
          if (exp_addr_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ack: got addr %h, none expected", imem.imem_addr);
          end else begin
            mon_val = exp_addr_q.pop_front();
            check32("imem_addr_at_ack", imem.imem_addr, mon_val);
          end
        end
        if (inst_valid && !stall) begin
          if (exp_pc_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_inst: got pc %h inst %h, none expected", inst_pc, inst);
          end else begin
            mon_val = exp_pc_q.pop_front();
            check32("inst_pc", inst_pc, mon_val);
            check32("inst", inst, mon_val ^ MASK);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; branch = 1'b0; trap = 1'b0; stall = 1'b0;
    branch_addr = '0; trap_addr = '0; ovr_ack = 1'b0; ovr_rdata = '0;

    // Reset state
    step(2); #3;
    check1("rst_req", imem.imem_req, 1'b0);
    check32("rst_addr", imem.imem_addr, 32'h0);
    check1("rst_inst_valid", inst_valid, 1'b0);
    check32("rst_inst", inst, 32'h0);
    check32("rst_inst_pc", inst_pc, 32'h0);
    check1("rst_misalign", misalign, 1'b0);
    check1("rst_fetch_err", fetch_err, 1'b0);

    // Sequential fetch with single-cycle memory
    exp_addr_q = '{32'h0, 32'h4, 32'h8};
    exp_pc_q   = '{32'h0, 32'h4, 32'h8};
    do_reset(1, 3);
    step(1); #3;
    check1("s1_first_req", imem.imem_req, 1'b1);
    check32("s1_first_addr", imem.imem_addr, 32'h0);
    step(1); #3;
    check32("s1_addr_second", imem.imem_addr, 32'h4);
    check32("s1_inst_pc_behind", inst_pc, 32'h0);
    step(8);
    check_drained("s1");

    // Branch during a slow fetch kills the outstanding word
    exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'h100};
    exp_pc_q   = '{32'h0, 32'h4, 32'h100};
    do_reset(4, 4);
    wait_addr("s2_wait8", 32'h8);
    @(negedge clk); branch = 1'b1; branch_addr = 32'h100;
    @(negedge clk); branch = 1'b0; #3;
    check32("s2_addr_held", imem.imem_addr, 32'h8);
    check1("s2_req_held", imem.imem_req, 1'b1);
    step(25);
    check_drained("s2");

    // Trap beats branch, redirect coincident with ack
    exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'h80, 32'h84};
    exp_pc_q   = '{32'h0, 32'h4, 32'h80, 32'h84};
    do_reset(1, 5);
    wait_addr("s3_wait4", 32'h4);
    @(negedge clk);
    trap = 1'b1; trap_addr = 32'h80; branch = 1'b1; branch_addr = 32'h40;
    @(negedge clk); trap = 1'b0; branch = 1'b0; #3;
    check32("s3_trap_wins", imem.imem_addr, 32'h80);
    step(8);
    check_drained("s3");

    // Stall for five cycles holds the presented word
    exp_addr_q = '{32'h0, 32'h4, 32'h8};
    exp_pc_q   = '{32'h0, 32'h4, 32'h8};
    do_reset(1, 3);
    wait_addr("s4_wait4", 32'h4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); stall = 1'b1; #3;
      check32("s4_hold_pc", inst_pc, 32'h4);
      check32("s4_hold_inst", inst, 32'h4 ^ MASK);
      check1("s4_hold_req", imem.imem_req, 1'b0);
    end
    @(negedge clk); stall = 1'b0; #3;
    check1("s4_release_valid", inst_valid, 1'b1);
    @(negedge clk); #3;
    check1("s4_resume_req", imem.imem_req, 1'b1);
    check32("s4_resume_addr", imem.imem_addr, 32'h8);
    step(5);
    check_drained("s4");

    // Misaligned branch target
    exp_addr_q = '{32'h0, 32'h100, 32'h104};
    exp_pc_q   = '{32'h100, 32'h104};
    do_reset(4, 3);
    wait_addr("s5_wait0", 32'h0);
    mis_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      branch = (i == 0); branch_addr = 32'h103;
      #3;
      if (misalign) mis_cnt++;
      if (i == 1) check1("s5_misalign_pulse", misalign, 1'b1);
    end
    check32("s5_misalign_cycles", mis_cnt, 32'd1);
    step(2);
    check_drained("s5");

    // Second redirect while one is pending replaces it
    exp_addr_q = '{32'h0, 32'h300, 32'h304};
    exp_pc_q   = '{32'h300, 32'h304};
    do_reset(4, 3);
    wait_addr("s6_wait0", 32'h0);
    @(negedge clk); branch = 1'b1; branch_addr = 32'h200;
    @(negedge clk); branch = 1'b0; trap = 1'b1; trap_addr = 32'h300;
    @(negedge clk); trap = 1'b0;
    step(15);
    check_drained("s6");

    // Redirect while holding drops the held word
    exp_addr_q = '{32'h0, 32'h4, 32'h40};
    exp_pc_q   = '{32'h0, 32'h40};
    do_reset(1, 3);
    wait_addr("s7_wait4", 32'h4);
    @(negedge clk); stall = 1'b1;
    @(negedge clk); branch = 1'b1; branch_addr = 32'h40;
    @(negedge clk); branch = 1'b0; stall = 1'b0; #3;
    check1("s7_dropped_valid", inst_valid, 1'b0);
    check32("s7_target_addr", imem.imem_addr, 32'h40);
    step(4);
    check_drained("s7");

    // PC wraps past the top of the address space
    exp_addr_q = '{32'h0, 32'hFFFF_FFFC, 32'h0};
    exp_pc_q   = '{32'hFFFF_FFFC, 32'h0};
    do_reset(1, 3);
    @(negedge clk); branch = 1'b1; branch_addr = 32'hFFFF_FFFC;
    @(negedge clk); branch = 1'b0; #3;
    check32("s10_top_addr", imem.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #3;
    check32("s10_wrap_addr", imem.imem_addr, 32'h0);
    step(3);
    check_drained("s10");

    // Reset mid-request; a stray ack during BOOT is ignored
    exp_addr_q = '{32'h0};
    exp_pc_q   = '{32'h0};
    do_reset(4, 0);
    step(3);
    rst = 1'b0; #1;
    check1("s8_async_req", imem.imem_req, 1'b0);
    check1("s8_async_valid", inst_valid, 1'b0);
    @(negedge clk);
    mem_lat = 1; ack_limit = acks_given + 1;
    rst = 1'b1; ovr_ack = 1'b1; ovr_rdata = 32'h0BAD_0BAD;
    @(negedge clk); ovr_ack = 1'b0; #3;
    check1("s8_first_req", imem.imem_req, 1'b1);
    check32("s8_first_addr", imem.imem_addr, 32'h0);
    step(4);
    check_drained("s8");

    // Timeout after 256 unanswered request cycles
    do_reset(1, 0);
    step(256); #3;
    check1("s9_err_before", fetch_err, 1'b0);
    check1("s9_req_before", imem.imem_req, 1'b1);
    @(negedge clk); #3;
    check1("s9_err_set", fetch_err, 1'b1);
    check1("s9_req_off", imem.imem_req, 1'b0);
    @(negedge clk); branch = 1'b1; branch_addr = 32'h40;
    @(negedge clk); branch = 1'b0;
    step(20); #3;
    check1("s9_err_sticky", fetch_err, 1'b1);
    check1("s9_req_stays_off", imem.imem_req, 1'b0);
    @(negedge clk); rst = 1'b0; #1;
    check1("s9_err_cleared", fetch_err, 1'b0);
    step(2);
    check_drained("s9");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles tolerated before a fetch error.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port branch  input  1  branch/jump redirect request from execute.
REQ-006 SHALL have port branch_addr  input  32  branch target.
REQ-007 SHALL have port trap  input  1  trap redirect request.
REQ-008 SHALL have port trap_addr  input  32  trap handler address.
REQ-009 SHALL have port stall  input  1  decode not ready to accept an instruction.
REQ-010 SHALL have port imem_req  output  1  instruction-memory request valid.
REQ-011 SHALL have port imem_addr  output  32  instruction-memory request address.
REQ-012 SHALL have port imem_ack  input  1  memory response valid; completes the request.
REQ-013 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-014 SHALL have port inst_valid  output  1  instruction presented to decode.
REQ-015 SHALL have port inst  output  32  instruction word.
REQ-016 SHALL have port inst_pc  output  32  address of inst.
REQ-017 SHALL have port misalign  output  1  one-cycle pulse when an accepted redirect target has addr[1:0] != 0.
REQ-018 SHALL have port fetch_err  output  1  sticky timeout flag.

Function
REQ-019 SHALL implement states BOOT, FETCH, HOLD, ERR.
REQ-020 BOOT SHALL last exactly one cycle after reset release, then go to FETCH with pc = RESET_VEC.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_ack.
REQ-022 On imem_ack with no kill pending and no redirect that cycle, the controller SHALL register inst = imem_rdata, inst_pc = pc and inst_valid = 1 on the next cycle.
REQ-023 On that same edge, pc SHALL become pc + 4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0.
REQ-024 If stall = 1 while inst_valid = 1, the controller SHALL go to HOLD, hold inst/inst_pc/inst_valid unchanged and keep imem_req = 0 until stall = 0.
REQ-025 Leaving HOLD, the controller SHALL return to FETCH with inst_valid deasserted unless a new instruction is accepted that cycle.
REQ-026 Redirect priority SHALL be trap > branch; a target SHALL have bits [1:0] forced to 00, and misalign SHALL pulse for that redirect.
REQ-027 A redirect during an outstanding request (FETCH, no ack) SHALL set kill, store the target in pend_pc, and leave imem_addr unchanged.
REQ-028 When the killed ack arrives, the controller SHALL discard the data, set pc = pend_pc and clear kill.
REQ-029 A redirect coincident with imem_ack SHALL discard the data, set pc = the target, and produce no inst_valid.
REQ-030 A redirect while pend_pc is already valid SHALL overwrite pend_pc; the most recent target wins.
REQ-031 A redirect in HOLD SHALL drop the held instruction, deassert inst_valid next cycle and enter FETCH at the target.
REQ-032 A wait counter SHALL count FETCH cycles with imem_req = 1 and imem_ack = 0, and clear on ack.
REQ-033 When the wait counter exceeds TIMEOUT, the controller SHALL set fetch_err = 1, enter ERR with imem_req = 0, and remain there until reset.

Reset
REQ-034 While rst = 0, the controller SHALL force state = BOOT, pc = RESET_VEC, pend_pc = 0, kill = 0, counter = 0, and imem_req, inst_valid, misalign, fetch_err = 0, and inst, inst_pc = 0, regardless of clk.
REQ-035 Reset asserted mid-request SHALL abandon the request; an imem_ack after reset release that arrives before the first FETCH SHALL be ignored.

Structure
REQ-036 The state encoding, the 32'd4 increment and the default vectors SHALL reside in shared package rv32i_pkg.
REQ-037 The redirect priority/alignment logic SHALL be one combinational sub-module, redirect_mux.

Verification
REQ-038 Reset release with 1-cycle ack latency -> imem_addr sequence 0x0, 0x4, 0x8 and inst_pc following one cycle behind.
REQ-039 Branch to 0x100 asserted 2 cycles into a 4-cycle-latency fetch of 0x8 -> data for 0x8 discarded, next imem_addr = 0x100, no inst_valid for 0x8.
REQ-040 Trap (0x80) and branch (0x40) asserted in the same cycle -> fetch resumes at 0x80.
REQ-041 stall held 5 cycles with inst_valid = 1 -> inst and inst_pc stable, imem_req = 0 throughout, then resumes at inst_pc + 4.
REQ-042 Branch target 0x103 -> fetch at 0x100 and misalign high for exactly 1 cycle.
REQ-043 imem_ack withheld for 256 cycles (TIMEOUT = 255) -> fetch_err = 1, imem_req = 0, sticky until rst = 0.
